// File: rtl/counter_pkg.sv
// Shared timer definitions: default counter width and the timer state encoding.
package counter_pkg;
  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } timer_state_t;
endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer; master drives controls, slave is the timer.
interface countdown_timer_if
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             st;
  logic [WIDTH-1:0] X;
  logic             start;
  logic             stop;
  logic             tick;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (output st, X, start, stop, tick, input out, busy, done);
  modport slave  (input st, X, start, stop, tick, output out, busy, done);
endinterface

// File: rtl/basic_decrement.sv
// Combinational in-1 over WIDTH bits; counterpart of the program-counter incrementer.
module basic_decrement #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_out
);
  assign o_out = i_in - WIDTH'(1);
endmodule

// File: rtl/countdown_timer.sv
// Loadable falling-edge down-counter with run/stop, registered expiry pulse and held reload value.
// Optional macro TIMER_AUTORELOAD_EN: on expiry reload the count and keep running (periodic mode).
module countdown_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  countdown_timer_if.slave bus
);
  timer_state_t     r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_done;

  timer_state_t     w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             w_done_nxt;
  logic [WIDTH-1:0] w_count_dec;

  basic_decrement #(.WIDTH(WIDTH)) u_dec (
    .i_in  (r_count),
    .o_out (w_count_dec)
  );

  // The whole machine shares the falling edge with the register file and PC.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    if (bus.st) begin
      w_count_nxt  = bus.X;
      w_reload_nxt = bus.X;
      w_state_nxt  = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!bus.stop && bus.start) begin
            if (r_count != '0) begin
              w_state_nxt = RUN;
            end else begin
              w_done_nxt  = 1'b1;
              w_state_nxt = EXPIRED;
            end
          end
        end
        RUN: begin
          // start has no effect while running, so tick is the next arbiter.
          if (bus.stop) begin
            w_state_nxt = IDLE;
          end else if (bus.tick) begin
            if (r_count == WIDTH'(1)) begin
              w_done_nxt = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
              w_count_nxt = r_reload;
`else
              w_count_nxt = '0;
              w_state_nxt = EXPIRED;
`endif
            end else if (r_count != '0) begin
              w_count_nxt = w_count_dec;
            end
          end
        end
        EXPIRED: begin
          if (bus.stop) begin
            w_state_nxt = IDLE;
          end else if (bus.start) begin
            w_count_nxt = r_reload;
            if (r_reload != '0) begin
              w_state_nxt = RUN;
            end else begin
              w_done_nxt = 1'b1;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.out  = r_count;
    bus.busy = (r_state == RUN);
    bus.done = r_done;
  end
endmodule
